div_radix4_seq: RTL and testbench

//  Parametrised iterative radix-4 unsigned fixed-point divider: Q = floor(X*2^WF / D), remainder R, 2 quotient bits/cycle.

---
 rtl/div_radix4_seq.sv | 182 ++++++++++++++++++
 tb/tb_div_radix4_seq.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_radix4_seq.sv
// Iterative radix-4 unsigned fixed-point divider, Q = floor(X*2^WF / D).
// Two quotient bits per enabled cycle, remainder out, div-by-zero and overflow flags.
//
// Ports:
//   CLK, RST (async, active-high), CE (clock enable; low freezes everything)
//   in_valid/in_ready + din_x, din_d  : operand handshake (ready only in IDLE)
//   out_valid/out_ready + dout, rem    : result handshake, held until taken
//   dz  : divisor was zero, dout saturated to all ones
//   ovf : quotient would not fit in WL bits, dout saturated to all ones
module div_radix4_seq #(
  parameter int WL = 24,
  parameter int WF = 23
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WL-1:0] din_x,
  input  logic [WL-1:0] din_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WL-1:0] dout,
  output logic [WL-1:0] rem,
  output logic          dz,
  output logic          ovf
);

  localparam int N  = (WL + 1) / 2;
  localparam int W2 = 2 * N;
  localparam int DW = WL + WF + 1;
  localparam int CW = $clog2(N + 1);
  localparam int TW = WL + 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [WL-1:0] r_p;
  logic [WL-1:0] r_d;
  logic [W2-1:0] r_sh;
  logic [W2-1:0] r_q;
  logic          r_in_ready;
  logic          r_out_valid;
  logic [WL-1:0] r_dout;
  logic [WL-1:0] r_rem;
  logic          r_dz;
  logic          r_ovf;

  logic [DW-1:0] w_dvd;
  logic [WL-1:0] w_p0;
  logic [WL-1:0] w_hi;
  logic          w_isz;
  logic          w_isovf;
  logic          w_acc;
  logic [TW-1:0] w_t;
  logic [TW-1:0] w_d1;
  logic [TW-1:0] w_d2;
  logic [TW-1:0] w_d3;
  logic [TW-1:0] w_sub;
  logic [1:0]    w_dig;
  logic [WL-1:0] w_pn;
  logic [W2-1:0] w_qn;

  // Full dividend X*2^WF with one spare top bit so odd WL gets
  // its leading pad digit. Everything above the low 2N bits is
  // already below D (no overflow), so it preloads the remainder.
  assign w_dvd   = DW'(din_x) << WF;
  assign w_p0    = WL'(w_dvd >> W2);
  assign w_hi    = din_x >> (WL - WF);
  assign w_isz   = (din_d == '0);
  assign w_isovf = (w_hi >= din_d);
  assign w_acc   = in_valid & r_in_ready;

  // T = 4P + next two dividend bits; P < D keeps T < 4D.
  assign w_t  = {r_p, r_sh[W2-1 -: 2]};
  assign w_d1 = TW'(r_d);
  assign w_d2 = w_d1 << 1;
  assign w_d3 = w_d1 + w_d2;

  // Exact digit selection: largest multiple of D not above T.
  always_comb begin
    w_dig = 2'd0;
    w_sub = '0;
    if (w_t >= w_d3) begin
      w_dig = 2'd3;
      w_sub = w_d3;
    end else if (w_t >= w_d2) begin
      w_dig = 2'd2;
      w_sub = w_d2;
    end else if (w_t >= w_d1) begin
      w_dig = 2'd1;
      w_sub = w_d1;
    end
  end

  assign w_pn = WL'(w_t - w_sub);
  assign w_qn = {r_q[W2-3:0], w_dig};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_p         <= '0;
      r_d         <= '0;
      r_sh        <= '0;
      r_q         <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_dout      <= '0;
      r_rem       <= '0;
      r_dz        <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (CE) begin
      unique case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_acc) begin
            r_in_ready <= 1'b0;
            r_d        <= din_d;
            r_dz       <= 1'b0;
            r_ovf      <= 1'b0;
            if (w_isz) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_dout      <= '1;
              r_rem       <= '0;
              r_dz        <= 1'b1;
            end else if (w_isovf) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_dout      <= '1;
              r_rem       <= '0;
              r_ovf       <= 1'b1;
            end else begin
              r_state <= S_CALC;
              r_cnt   <= '0;
              r_p     <= w_p0;
              r_sh    <= w_dvd[W2-1:0];
              r_q     <= '0;
            end
          end
        end
        S_CALC: begin
          r_p   <= w_pn;
          r_sh  <= {r_sh[W2-3:0], 2'b00};
          r_q   <= w_qn;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N - 1)) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_dout      <= w_qn[WL-1:0];
            r_rem       <= w_pn;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_in_ready <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign rem       = r_rem;
  assign dz        = r_dz;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_div_radix4_seq.sv
// Self-checking bench for div_radix4_seq (WL=24/WF=23 and WL=17/WF=8).
// Directed vectors, stalls, reset abort, randomized back-to-back vs model.
module tb_div_radix4_seq;

  localparam int WL  = 24;
  localparam int WF  = 23;
  localparam int NA  = 12;
  localparam int WLB = 17;
  localparam int WFB = 8;
  localparam int NB  = 9;

  localparam logic [23:0] VX [5] = '{24'h333333, 24'h400000, 24'h000000,
                                     24'h333333, 24'h7FFFFF};
  localparam logic [23:0] VD [5] = '{24'h599999, 24'h400000, 24'h123456,
                                     24'h000000, 24'h200000};
  localparam logic [23:0] VQ [5] = '{24'h492492, 24'h800000, 24'h000000,
                                     24'hFFFFFF, 24'hFFFFFF};
  localparam logic [23:0] VR [5] = '{24'h2BE2BE, 24'h0, 24'h0, 24'h0, 24'h0};
  localparam logic        VZ [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic        VO [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  localparam int          VL [5] = '{NA, NA, NA, 0, 0};

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] din_x;
  logic [23:0] din_d;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] dout;
  logic [23:0] rem;
  logic        dz;
  logic        ovf;

  logic        in_valid_b;
  logic        in_ready_b;
  logic [16:0] din_x_b;
  logic [16:0] din_d_b;
  logic        out_valid_b;
  logic        out_ready_b;
  logic [16:0] dout_b;
  logic [16:0] rem_b;
  logic        dz_b;
  logic        ovf_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_radix4_seq #(.WL(WL), .WF(WF)) u_a (
    .CLK(clk), .RST(rst), .CE(ce),
    .in_valid(in_valid), .in_ready(in_ready),
    .din_x(din_x), .din_d(din_d),
    .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .rem(rem), .dz(dz), .ovf(ovf)
  );

  div_radix4_seq #(.WL(WLB), .WF(WFB)) u_b (
    .CLK(clk), .RST(rst), .CE(ce),
    .in_valid(in_valid_b), .in_ready(in_ready_b),
    .din_x(din_x_b), .din_d(din_d_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b),
    .dout(dout_b), .rem(rem_b), .dz(dz_b), .ovf(ovf_b)
  );

  function automatic void model(input int wl, input int wf,
                                input longint unsigned x,
                                input longint unsigned d,
                                output longint unsigned q,
                                output longint unsigned r,
                                output bit fz, output bit fo);
    longint unsigned lim;
    longint unsigned n;
    lim = 64'd1 << wl;
    n   = x << wf;
    fz  = 1'b0;
    fo  = 1'b0;
    if (d == 0) begin
      q  = lim - 1;
      r  = 0;
      fz = 1'b1;
    end else begin
      q = n / d;
      if (q >= lim) begin
        q  = lim - 1;
        r  = 0;
        fo = 1'b1;
      end else begin
        r = n - q * d;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_a(input logic [23:0] x, input logic [23:0] d,
                          output bit ok);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    ok       = in_ready;
    in_valid = 1'b1;
    din_x    = x;
    din_d    = d;
    tick();
    in_valid = 1'b0;
    din_x    = 24'($urandom);
    din_d    = 24'($urandom);
  endtask

  task automatic wait_a(output int lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_a();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_ready: got %b exp 0", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b exp 0", out_valid);
    end
    checks++;
    if ({dout, rem, dz, ovf} !== 50'd0) begin
      errors++;
      $display("FAIL rst_outputs: got dout=%h rem=%h dz=%b ovf=%b exp 0",
               dout, rem, dz, ovf);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || in_ready_b !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready: got %b/%b exp 1/1",
               in_ready, in_ready_b);
    end
  endtask

  task automatic test_vectors();
    bit ok;
    int lat;
    for (int i = 0; i < 5; i++) begin
      accept_a(VX[i], VD[i], ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL vec%0d_accept: in_ready got 0 exp 1", i);
      end
      if (VL[i] != 0) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL vec%0d_busy: in_ready got %b exp 0", i, in_ready);
        end
      end
      wait_a(lat);
      checks++;
      if (lat != VL[i]) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d exp %0d", i, lat, VL[i]);
      end
      checks++;
      if (dout !== VQ[i] || rem !== VR[i]) begin
        errors++;
        $display("FAIL vec%0d_result: got q=%h r=%h exp q=%h r=%h",
                 i, dout, rem, VQ[i], VR[i]);
      end
      checks++;
      if (dz !== VZ[i] || ovf !== VO[i]) begin
        errors++;
        $display("FAIL vec%0d_flags: got dz=%b ovf=%b exp dz=%b ovf=%b",
                 i, dz, ovf, VZ[i], VO[i]);
      end
      release_a();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_release: out_valid got %b exp 0", i, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    bit ok;
    int lat;
    accept_a(24'h333333, 24'h599999, ok);
    lat = 0;
    while (!out_valid && lat < 60) begin
      ce = (lat >= 4 && lat < 7) ? 1'b0 : 1'b1;
      tick();
      lat++;
    end
    ce = 1'b1;
    checks++;
    if (lat != NA + 3) begin
      errors++;
      $display("FAIL stall_latency: got %0d exp %0d", lat, NA + 3);
    end
    checks++;
    if (dout !== 24'h492492 || rem !== 24'h2BE2BE) begin
      errors++;
      $display("FAIL stall_result: got q=%h r=%h exp q=492492 r=2be2be",
               dout, rem);
    end
    ce        = 1'b0;
    out_ready = 1'b1;
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ce_freeze_done: out_valid got %b exp 1", out_valid);
    end
    out_ready = 1'b0;
    ce        = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      din_x    = 24'($urandom);
      din_d    = 24'($urandom);
      tick();
      checks++;
      if ({out_valid, in_ready, dout, rem, dz, ovf} !==
          {1'b1, 1'b0, 24'h492492, 24'h2BE2BE, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL hold%0d: got v=%b rdy=%b q=%h r=%h dz=%b ovf=%b exp 1 0 492492 2be2be 0 0",
                 k, out_valid, in_ready, dout, rem, dz, ovf);
      end
    end
    in_valid = 1'b0;
    release_a();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release: got v=%b rdy=%b exp 0 1",
               out_valid, in_ready);
    end
  endtask

  task automatic test_rst_mid();
    bit ok;
    int lat;
    accept_a(24'h333333, 24'h599999, ok);
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, in_ready, dout, rem, dz, ovf} !== 52'd0) begin
      errors++;
      $display("FAIL abort_outputs: got v=%b rdy=%b q=%h r=%h exp all 0",
               out_valid, in_ready, dout, rem);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_release: got rdy=%b v=%b exp 1 0",
               in_ready, out_valid);
    end
    accept_a(24'h400000, 24'h400000, ok);
    wait_a(lat);
    checks++;
    if (lat != NA || dout !== 24'h800000 || rem !== 24'h0) begin
      errors++;
      $display("FAIL after_abort: got lat=%0d q=%h r=%h exp %0d 800000 0",
               lat, dout, rem, NA);
    end
    release_a();
  endtask

  task automatic test_random_a(input int cnt);
    logic [23:0] x;
    logic [23:0] d;
    longint unsigned q;
    longint unsigned r;
    bit fz;
    bit fo;
    bit ok;
    bit hs;
    int sel;
    int lat;
    int n;
    int elat;
    for (int i = 0; i < cnt; i++) begin
      sel = $urandom_range(0, 15);
      x   = 24'($urandom);
      if (sel == 15) x = 24'($urandom_range(0, 1000));
      if (sel == 0) d = 24'h0;
      else if (sel < 4) d = 24'($urandom_range(1, 255));
      else if (sel < 6) d = x;
      else d = 24'($urandom);
      model(WL, WF, longint'(x), longint'(d), q, r, fz, fo);
      elat = (fz || fo) ? 0 : NA;
      accept_a(x, d, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL rnd%0d_accept: in_ready got 0 exp 1", i);
      end
      lat = 0;
      while (!out_valid && lat < 60) begin
        in_valid = 1'($urandom);
        tick();
        lat++;
      end
      in_valid = 1'b0;
      checks++;
      if (lat != elat) begin
        errors++;
        $display("FAIL rnd%0d_latency: got %0d exp %0d", i, lat, elat);
      end
      checks++;
      if ({dout, rem, dz, ovf} !== {q[23:0], r[23:0], fz, fo}) begin
        errors++;
        $display("FAIL rnd%0d x=%h d=%h: got q=%h r=%h dz=%b ovf=%b exp q=%h r=%h dz=%b ovf=%b",
                 i, x, d, dout, rem, dz, ovf, q[23:0], r[23:0], fz, fo);
      end
      n = 0;
      do begin
        out_ready = (n > 8) ? 1'b1 : 1'($urandom);
        hs        = out_ready;
        tick();
        n++;
        if (!hs) begin
          checks++;
          if ({out_valid, dout, rem} !== {1'b1, q[23:0], r[23:0]}) begin
            errors++;
            $display("FAIL rnd%0d_hold: got v=%b q=%h r=%h exp 1 %h %h",
                     i, out_valid, dout, rem, q[23:0], r[23:0]);
          end
        end
      end while (!hs);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_random_b(input int cnt);
    logic [16:0] x;
    logic [16:0] d;
    longint unsigned q;
    longint unsigned r;
    bit fz;
    bit fo;
    int sel;
    int lat;
    int elat;
    for (int i = 0; i < cnt; i++) begin
      sel = $urandom_range(0, 15);
      x   = 17'($urandom);
      if (sel == 0) d = 17'h0;
      else if (sel < 6) d = 17'($urandom_range(1, 1023));
      else d = 17'($urandom);
      model(WLB, WFB, longint'(x), longint'(d), q, r, fz, fo);
      elat = (fz || fo) ? 0 : NB;
      lat  = 0;
      while (!in_ready_b && lat < 50) begin
        tick();
        lat++;
      end
      in_valid_b = 1'b1;
      din_x_b    = x;
      din_d_b    = d;
      tick();
      in_valid_b = 1'b0;
      din_x_b    = 17'($urandom);
      din_d_b    = 17'($urandom);
      lat = 0;
      while (!out_valid_b && lat < 60) begin
        tick();
        lat++;
      end
      checks++;
      if (lat != elat) begin
        errors++;
        $display("FAIL b%0d_latency: got %0d exp %0d", i, lat, elat);
      end
      checks++;
      if ({dout_b, rem_b, dz_b, ovf_b} !== {q[16:0], r[16:0], fz, fo}) begin
        errors++;
        $display("FAIL b%0d x=%h d=%h: got q=%h r=%h dz=%b ovf=%b exp q=%h r=%h dz=%b ovf=%b",
                 i, x, d, dout_b, rem_b, dz_b, ovf_b, q[16:0], r[16:0], fz, fo);
      end
      out_ready_b = 1'b1;
      tick();
      out_ready_b = 1'b0;
    end
  endtask

  initial begin
    rst         = 1'b1;
    ce          = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    din_x       = '0;
    din_d       = '0;
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    din_x_b     = '0;
    din_d_b     = '0;
    test_reset();
    test_vectors();
    test_stall();
    test_rst_mid();
    test_random_a(2500);
    test_random_b(1500);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
